multicycle_main_ctrl: RTL and testbench
=======================================

Name: multicycle_main_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back over several clocks.
- It drives the PC, IR, memory, register-file and ALU-source control lines from the latched opcode, and waits on a memory-ready handshake.
- It replaces the single-cycle opcode decoder. The existing ALU_Ctrl block consumes its ALU_op_o together with funct.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_op_i  in  6  opcode field of the IR; valid from DECODE onward
- mem_ready_i  in  1  memory completes the current access this cycle
- mem_req_o  out  1  memory access request
- MemRead_o  out  1  read strobe
- MemWrite_o  out  1  write strobe
- IorD_o  out  1  memory address select: 0=PC, 1=ALUOut
- IRWrite_o  out  1  load IR
- PCWrite_o  out  1  unconditional PC load
- PCWriteCond_o  out  1  PC load if ALU zero
- PCSource_o  out  2  PC mux select: 00=ALU, 01=ALUOut, 10=jump target
- ALU_op_o  out  3  000=R-type, 001=add, 010=slt, 100=sub/beq
- ALUSrcA_o  out  1  ALU A select: 0=PC, 1=rs
- ALUSrcB_o  out  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- RegDst_o  out  1  write-register select: 1=rd, 0=rt
- MemtoReg_o  out  1  write-data select: 1=MDR, 0=ALUOut
- RegWrite_o  out  1  register-file write enable
- illegal_o  out  1  sticky: unsupported opcode trapped
- instr_cnt_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst_i low asynchronously forces state IDLE, instr_cnt_o=0 and illegal_o=0. All control outputs are 0 while in IDLE.
- IDLE always moves to FETCH on the next edge after reset release.
- Outputs are Moore (decoded from state) except the FETCH write strobes, which are gated by mem_ready_i.
- FETCH:
  - Drives mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=001, PCSource=00.
  - IRWrite and PCWrite assert only in the cycle mem_ready_i=1.
  - Holds state while mem_ready_i=0; goes to DECODE on ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=001 (branch target to ALUOut). Next state by opcode:
  - 000000 R-type -> EXEC_R
  - 001000 addi -> EXEC_I
  - 001010 slti -> EXEC_I
  - 100011 lw -> MEM_ADDR
  - 101011 sw -> MEM_ADDR
  - 000100 beq -> BRANCH
  - 000010 j -> JUMP
  - any other -> TRAP
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_op=000; then R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1; then FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALU_op=001 (addi) or 010 (slti), chosen from instr_op_i; then I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1; then FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=001; then MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, MemRead=1, IorD=1. Holds until mem_ready_i=1, then MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1; then FETCH.
- MEM_WR: mem_req=1, MemWrite=1, IorD=1. Holds until mem_ready_i=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=100, PCWriteCond=1, PCSource=01; then FETCH.
- JUMP: PCWrite=1, PCSource=10; then FETCH.
- TRAP: all control outputs 0; illegal_o=1. Remains in TRAP until reset.
- instr_cnt_o increments by 1 on the final edge of each instruction: R_WB, I_WB, MEM_WB, MEM_WR with ready, BRANCH, JUMP. It wraps modulo 2^CNT_W and is never incremented for a trapped opcode.
- Zero-wait latencies: R-type 4, addi/slti 4, lw 5, sw 4, beq 3, j 3 cycles. Each wait cycle adds one.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-instruction abandons it: no partial RegWrite/PCWrite after the reset edge, and the count is not incremented.
- Don't-care selects in states that do not use them are driven 0 (no X on any output).

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum: 4 bits, 14 states
  - opcode constants
  - ALU_op codes 000/001/010/100
  - ALUSrcB and PCSource encodings
- Single module; no sub-module required. The next-state logic and output decode are two always blocks in one file.

Test Plan:
- Reset release, mem_ready_i=1, opcode 000000 -> IDLE, FETCH(IRWrite=PCWrite=1), DECODE, EXEC_R(ALU_op=000), R_WB(RegWrite=1, RegDst=1); instr_cnt_o=1 after 5 edges.
- lw (100011) with mem_ready_i low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with IorD=1, MemRead=1; MEM_WB has MemtoReg=1, RegWrite=1; instruction takes 7 cycles.
- beq (000100) then slti (001010) -> BRANCH: PCWriteCond=1, PCSource=01, ALU_op=100. EXEC_I: ALU_op=010, ALUSrcB=10. Count advances by 2.
- Opcode 111111 -> TRAP after DECODE; illegal_o=1 and held; all strobes 0 for 20 cycles; count unchanged.
- rst_i pulsed low during MEM_WR with mem_ready_i=0 -> outputs 0 immediately; MemWrite never asserted with ready; count=0; FETCH follows one cycle after release.
- Preload near wrap (CNT_W=4, 15 instructions then 1 more j) -> instr_cnt_o goes 15 -> 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// state encoding, opcodes and the ALU/mux select encodings it drives.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_R_WB     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/write-back, counts
// retired instructions and traps on unsupported opcodes.
module multicycle_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IorD_o,
    output logic             IRWrite_o,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic [1:0]       PCSource_o,
    output logic [2:0]       ALU_op_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic             RegDst_o,
    output logic             MemtoReg_o,
    output logic             RegWrite_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    state_t state, next_state;
    logic   retire;
    logic   trap_enter;

    // State register, retired-instruction counter and sticky trap flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            instr_cnt_o <= '0;
            illegal_o   <= 1'b0;
        end else begin
            state <= next_state;
            if (retire)
                instr_cnt_o <= instr_cnt_o + CNT_W'(1);
            if (trap_enter)
                illegal_o <= 1'b1;
        end
    end

    // Next-state selection; also flags the last edge of each instruction
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        trap_enter = 1'b0;
        unique case (state)
            S_IDLE:     next_state = S_FETCH;
            S_FETCH:    if (mem_ready_i) next_state = S_DECODE;
            S_DECODE: begin
                case (instr_op_i)
                    OP_RTYPE:        next_state = S_EXEC_R;
                    OP_ADDI, OP_SLTI: next_state = S_EXEC_I;
                    OP_LW, OP_SW:    next_state = S_MEM_ADDR;
                    OP_BEQ:          next_state = S_BRANCH;
                    OP_J:            next_state = S_JUMP;
                    default: begin
                        next_state = S_TRAP;
                        trap_enter = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:   next_state = S_R_WB;
            S_EXEC_I:   next_state = S_I_WB;
            S_MEM_ADDR: next_state = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready_i) next_state = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_IDLE;
        endcase
    end

    // Control-line decode from state; only fetch strobes look at mem_ready_i
    always_comb begin
        mem_req_o     = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IorD_o        = 1'b0;
        IRWrite_o     = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        PCSource_o    = PCSRC_ALU;
        ALU_op_o      = ALU_RTYPE;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = SRCB_RT;
        RegDst_o      = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_o  = 1'b1;
                MemRead_o  = 1'b1;
                ALUSrcB_o  = SRCB_FOUR;
                ALU_op_o   = ALU_ADD;
                IRWrite_o  = mem_ready_i;
                PCWrite_o  = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB_o = SRCB_IMM_SH;
                ALU_op_o  = ALU_ADD;
            end
            S_EXEC_R: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_RT;
                ALU_op_o  = ALU_RTYPE;
            end
            S_R_WB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
                ALU_op_o  = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_I_WB:     RegWrite_o = 1'b1;
            S_MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
                ALU_op_o  = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_o  = 1'b1;
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUSrcB_o     = SRCB_RT;
                ALU_op_o      = ALU_SUB;
                PCWriteCond_o = 1'b1;
                PCSource_o    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Directed bench for multicycle_main_ctrl: a table of per-cycle vectors
// walking several instruction types, plus hand-written trap, reset and
// counter-wrap sequences. Counter width is shrunk to 4 bits.
module tb_multicycle_main_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       mem_ready_i;
    logic       mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o;
    logic       PCWrite_o, PCWriteCond_o;
    logic [1:0] PCSource_o;
    logic [2:0] ALU_op_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic       RegDst_o, MemtoReg_o, RegWrite_o, illegal_o;
    logic [3:0] instr_cnt_o;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        ready;
        logic [17:0] ctrl;
        logic        ill;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    // Expected control words, bit order matches actualCtrl()
    logic [17:0] cIdle, cFetch, cFetchWait, cDec, cExR, cRwb, cExIAdd, cExISlt;
    logic [17:0] cIwb, cMaddr, cMrd, cMwb, cMwr, cBr, cJ;

    multicycle_main_ctrl #(.CNT_W(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_op_i    (instr_op_i),
        .mem_ready_i   (mem_ready_i),
        .mem_req_o     (mem_req_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .IorD_o        (IorD_o),
        .IRWrite_o     (IRWrite_o),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .PCSource_o    (PCSource_o),
        .ALU_op_o      (ALU_op_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .RegDst_o      (RegDst_o),
        .MemtoReg_o    (MemtoReg_o),
        .RegWrite_o    (RegWrite_o),
        .illegal_o     (illegal_o),
        .instr_cnt_o   (instr_cnt_o)
    );

    // 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [17:0] mk(
        logic req, logic rd, logic wr, logic iord, logic irw, logic pcw,
        logic pcwc, logic [1:0] pcsrc, logic [2:0] aluop, logic srca,
        logic [1:0] srcb, logic regdst, logic m2r, logic regw);
        return {req, rd, wr, iord, irw, pcw, pcwc, pcsrc, aluop, srca, srcb, regdst, m2r, regw};
    endfunction

    function automatic logic [17:0] actualCtrl();
        return {mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o,
                PCWriteCond_o, PCSource_o, ALU_op_o, ALUSrcA_o, ALUSrcB_o,
                RegDst_o, MemtoReg_o, RegWrite_o};
    endfunction

    task automatic addVec(input logic [5:0] op, input logic ready,
                          input logic [17:0] ctrl, input logic ill, input logic [3:0] cnt);
        vec_t v;
        v.op = op; v.ready = ready; v.ctrl = ctrl; v.ill = ill; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, then let decode settle
    task automatic applyStimulus(input logic [5:0] op, input logic ready);
        @(negedge clk_i);
        instr_op_i  = op;
        mem_ready_i = ready;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [17:0] expCtrl,
                               input logic expIll, input logic [3:0] expCnt);
        logic [17:0] act;
        act = actualCtrl();
        total++;
        if (act !== expCtrl || illegal_o !== expIll || instr_cnt_o !== expCnt) begin
            bad++;
            $display("[TB] FAIL %s: ctrl=%b ill=%b cnt=%0d, expected ctrl=%b ill=%b cnt=%0d",
                     name, act, illegal_o, instr_cnt_o, expCtrl, expIll, expCnt);
        end
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
    endtask

    initial begin
        rst_i       = 1'b0;
        instr_op_i  = '0;
        mem_ready_i = 1'b0;

        //          req rd wr iord irw pcw pcwc pcsrc  aluop   srca srcb   rdst m2r rw
        cIdle      = '0;
        cFetch     = mk(1, 1, 0, 0, 1, 1, 0, 2'b00, 3'b001, 0, 2'b01, 0, 0, 0);
        cFetchWait = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b001, 0, 2'b01, 0, 0, 0);
        cDec       = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b001, 0, 2'b11, 0, 0, 0);
        cExR       = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 2'b00, 0, 0, 0);
        cRwb       = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 1);
        cExIAdd    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b001, 1, 2'b10, 0, 0, 0);
        cExISlt    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 1, 2'b10, 0, 0, 0);
        cIwb       = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 1);
        cMaddr     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b001, 1, 2'b10, 0, 0, 0);
        cMrd       = mk(1, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 0);
        cMwb       = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 1, 1);
        cMwr       = mk(1, 0, 1, 1, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 0);
        cBr        = mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 3'b100, 1, 2'b00, 0, 0, 0);
        cJ         = mk(0, 0, 0, 0, 0, 1, 0, 2'b10, 3'b000, 0, 2'b00, 0, 0, 0);

        // R-type, zero wait
        addVec(R,    1, cIdle,      0, 0);
        addVec(R,    1, cFetch,     0, 0);
        addVec(R,    1, cDec,       0, 0);
        addVec(R,    0, cExR,       0, 0);
        addVec(R,    1, cRwb,       0, 0);
        // lw with two wait cycles in MEM_RD
        addVec(R,    1, cFetch,     0, 1);
        addVec(LW,   0, cDec,       0, 1);
        addVec(LW,   1, cMaddr,     0, 1);
        addVec(LW,   0, cMrd,       0, 1);
        addVec(LW,   0, cMrd,       0, 1);
        addVec(LW,   1, cMrd,       0, 1);
        addVec(LW,   0, cMwb,       0, 1);
        // fetch stall, then beq
        addVec(R,    0, cFetchWait, 0, 2);
        addVec(R,    1, cFetch,     0, 2);
        addVec(BEQ,  1, cDec,       0, 2);
        addVec(BEQ,  1, cBr,        0, 2);
        // slti
        addVec(R,    1, cFetch,     0, 3);
        addVec(SLTI, 1, cDec,       0, 3);
        addVec(SLTI, 1, cExISlt,    0, 3);
        addVec(SLTI, 1, cIwb,       0, 3);
        // addi
        addVec(R,    1, cFetch,     0, 4);
        addVec(ADDI, 0, cDec,       0, 4);
        addVec(ADDI, 0, cExIAdd,    0, 4);
        addVec(ADDI, 0, cIwb,       0, 4);
        // sw with one wait
        addVec(R,    1, cFetch,     0, 5);
        addVec(SW,   1, cDec,       0, 5);
        addVec(SW,   1, cMaddr,     0, 5);
        addVec(SW,   0, cMwr,       0, 5);
        addVec(SW,   1, cMwr,       0, 5);
        // j
        addVec(R,    1, cFetch,     0, 6);
        addVec(JMP,  1, cDec,       0, 6);
        addVec(JMP,  0, cJ,         0, 6);
        // unsupported opcode
        addVec(R,    1, cFetch,     0, 7);
        addVec(BAD,  1, cDec,       0, 7);
        addVec(BAD,  1, cIdle,      1, 7);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].ill, vecs[i].cnt);
        end

        // Trap is sticky regardless of inputs
        for (int i = 0; i < 20; i++) begin
            applyStimulus(6'($urandom), 1'($urandom));
            checkOutput($sformatf("trapHold%0d", i), cIdle, 1'b1, 4'd7);
        end

        // Reset clears trap; then abandon a sw mid-MEM_WR
        doReset();
        applyStimulus(R, 1);   checkOutput("rstIdle", cIdle, 0, 0);
        applyStimulus(R, 1);   checkOutput("jFetch", cFetch, 0, 0);
        applyStimulus(JMP, 1);
        applyStimulus(JMP, 1); checkOutput("jJump", cJ, 0, 0);
        applyStimulus(R, 1);   checkOutput("swFetch", cFetch, 0, 1);
        applyStimulus(SW, 1);
        applyStimulus(SW, 1);
        applyStimulus(SW, 0);  checkOutput("swWait", cMwr, 0, 1);
        #2;
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        checkOutput("rstImmediate", cIdle, 0, 0);
        @(posedge clk_i);
        #1;
        checkOutput("rstHeld", cIdle, 0, 0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        applyStimulus(R, 1);   checkOutput("postRstIdle", cIdle, 0, 0);
        applyStimulus(R, 1);   checkOutput("postRstFetch", cFetch, 0, 0);

        // Counter wrap with 16 jumps on a 4-bit counter
        doReset();
        applyStimulus(R, 1);   checkOutput("wrapIdle", cIdle, 0, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(R, 1);
            checkOutput($sformatf("wrapFetch%0d", i), cFetch, 0, 4'(i));
            applyStimulus(JMP, 1);
            applyStimulus(JMP, 1);
        end
        applyStimulus(R, 1);   checkOutput("wrapZero", cFetch, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
